iob_cache_line_fill_buffer: RTL and testbench

- Downstream consumer of the cache AXI read channel during a line replacement.
- Collects the BE_DATA_W-wide beats written by that channel into one full-line register.
- Once the refill ends, presents the complete line, its index and an error flag to the data-memory/tag-update stage over a valid/ready handshake.
- Also returns the CPU-requested word to the front-end.

---
 rtl/iob_cache_line_fill_buffer_if.sv | 41 ++++
 rtl/iob_cache_line_fill_buffer.sv | 126 ++++++++++++
 tb/tb_iob_cache_line_fill_buffer.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/iob_cache_line_fill_buffer_if.sv
// Signal bundle between the AXI read channel, the line fill buffer and its consumers.
// slave = fill buffer side, master = driving/observing side.
interface iob_cache_line_fill_buffer_if #(
   parameter int unsigned DATA_W        = 32,
   parameter int unsigned BE_DATA_W     = 256,
   parameter int unsigned WORD_OFFSET_W = 3,
   parameter int unsigned NLINES_W      = 7,
   parameter int unsigned LINE2BE_W     = WORD_OFFSET_W - $clog2(BE_DATA_W / DATA_W),
   parameter int unsigned LINE_W        = DATA_W * (2 ** WORD_OFFSET_W)
) ();
   localparam int unsigned RADDR_W = (LINE2BE_W == 0) ? 1 : LINE2BE_W;

   logic                     replace_i;
   logic [NLINES_W-1:0]      req_index_i;
   logic [WORD_OFFSET_W-1:0] req_woffset_i;
   logic                     read_valid_i;
   logic [RADDR_W-1:0]       read_addr_i;
   logic [BE_DATA_W-1:0]     read_rdata_i;
   logic                     line_valid_o;
   logic                     line_ready_i;
   logic [NLINES_W-1:0]      line_index_o;
   logic [LINE_W-1:0]        line_data_o;
   logic                     line_err_o;
   logic                     word_valid_o;
   logic [DATA_W-1:0]        word_rdata_o;
   logic                     busy_o;

   modport slave (
      input  replace_i, req_index_i, req_woffset_i, read_valid_i, read_addr_i, read_rdata_i,
             line_ready_i,
      output line_valid_o, line_index_o, line_data_o, line_err_o, word_valid_o, word_rdata_o,
             busy_o
   );

   modport master (
      output replace_i, req_index_i, req_woffset_i, read_valid_i, read_addr_i, read_rdata_i,
             line_ready_i,
      input  line_valid_o, line_index_o, line_data_o, line_err_o, word_valid_o, word_rdata_o,
             busy_o
   );
endinterface

// File: rtl/iob_cache_line_fill_buffer.sv
// Assembles AXI refill beats into a full cache line and hands it to the tag/data update stage.
// IOB_CACHE_CRITICAL_WORD_FWD_EN: forward the requested word as soon as its beat arrives.
module iob_cache_line_fill_buffer #(
   parameter int unsigned ADDR_W        = 32,
   parameter int unsigned DATA_W        = 32,
   parameter int unsigned BE_DATA_W     = 256,
   parameter int unsigned WORD_OFFSET_W = 3,
   parameter int unsigned NLINES_W      = 7,
   parameter int unsigned LINE2BE_W     = WORD_OFFSET_W - $clog2(BE_DATA_W / DATA_W),
   parameter int unsigned LINE_W        = DATA_W * (2 ** WORD_OFFSET_W)
) (
   input logic                         clk_i,
   input logic                         reset_n_i,
   iob_cache_line_fill_buffer_if.slave bus
);
   localparam int unsigned NBEATS = 2 ** LINE2BE_W;
   localparam int unsigned SLOT_W = (LINE2BE_W == 0) ? 1 : LINE2BE_W;
   localparam int unsigned WPB_W  = WORD_OFFSET_W - LINE2BE_W;
   localparam int unsigned WPB    = 2 ** WPB_W;

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] FILL   = 2'd1;
   localparam logic [1:0] COMMIT = 2'd2;

   logic [1:0]               state_q, state_d;
   logic                     replace_q;
   logic                     rise, fall;
   logic [NLINES_W-1:0]      index_q;
   logic [WORD_OFFSET_W-1:0] woffset_q;
   logic [31:0]              woff_ext;
   logic [LINE_W-1:0]        line_q, line_d;
   logic [NBEATS-1:0]        mask_q, mask_d;
   logic [SLOT_W-1:0]        slot;
   logic                     word_valid_q, word_valid_d;
   logic [DATA_W-1:0]        word_q, word_d;
   logic                     unused_ok;

   // A single-beat line has only slot 0, so the beat address carries no information.
   if (LINE2BE_W == 0) begin : g_one_slot
      assign slot = '0;
   end else begin : g_slots
      assign slot = bus.read_addr_i;
   end

   assign unused_ok = (^bus.read_addr_i) ^ (ADDR_W == 0);

   assign rise     = bus.replace_i & ~replace_q;
   assign fall     = ~bus.replace_i & replace_q;
   assign woff_ext = 32'(woffset_q);

   always_comb begin
      state_d      = state_q;
      line_d       = line_q;
      mask_d       = mask_q;
      word_valid_d = 1'b0;
      word_d       = word_q;
      case (state_q)
         IDLE: begin
            if (rise) begin
               state_d = FILL;
               mask_d  = '0;
            end
         end
         FILL: begin
            if (bus.read_valid_i) begin
               line_d[32'(slot) * BE_DATA_W +: BE_DATA_W] = bus.read_rdata_i;
               // Slot 0 arriving on a partly filled line means the slave restarted the burst.
               if (slot == '0 && mask_q != '0)
                  mask_d = NBEATS'(1);
               else
                  mask_d = mask_q | (NBEATS'(1) << slot);
            end
`ifdef IOB_CACHE_CRITICAL_WORD_FWD_EN
            if (bus.read_valid_i && (32'(slot) == (woff_ext >> WPB_W))) begin
               word_valid_d = 1'b1;
               word_d       = bus.read_rdata_i[(woff_ext % WPB) * DATA_W +: DATA_W];
            end
`else
            if (fall && mask_d == '1) begin
               word_valid_d = 1'b1;
               word_d       = line_d[woff_ext * DATA_W +: DATA_W];
            end
`endif
            if (fall)
               state_d = COMMIT;
         end
         COMMIT: begin
            if (bus.line_ready_i)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q      <= IDLE;
         replace_q    <= 1'b0;
         index_q      <= '0;
         woffset_q    <= '0;
         line_q       <= '0;
         mask_q       <= '0;
         word_valid_q <= 1'b0;
         word_q       <= '0;
      end else begin
         state_q      <= state_d;
         replace_q    <= bus.replace_i;
         line_q       <= line_d;
         mask_q       <= mask_d;
         word_valid_q <= word_valid_d;
         word_q       <= word_d;
         if (state_q == IDLE && rise) begin
            index_q   <= bus.req_index_i;
            woffset_q <= bus.req_woffset_i;
         end
      end
   end

   assign bus.line_valid_o = (state_q == COMMIT);
   assign bus.line_index_o = index_q;
   assign bus.line_data_o  = line_q;
   assign bus.line_err_o   = (state_q == COMMIT) && (mask_q != '1);
   assign bus.word_valid_o = word_valid_q;
   assign bus.word_rdata_o = word_q;
   assign bus.busy_o       = (state_q != IDLE);
endmodule

// File: tb/tb_iob_cache_line_fill_buffer.sv
// Scoreboard bench: dut0 has four 64-bit beats per line, dut1 a single 256-bit beat.
module tb_iob_cache_line_fill_buffer;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_n;
   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_bad = 0;

   typedef struct {
      logic [6:0]   idx;
      logic [255:0] data;
      logic         err;
      logic         chk_data;
      int unsigned  cyc;
   } line_t;
   typedef struct {
      logic [31:0] data;
      int unsigned cyc;
   } word_t;

   line_t exp_line[2][$];
   word_t exp_word[2][$];
   logic  seen[2];

   logic         replace[2], rvalid[2], ready[2];
   logic [6:0]   ridx[2];
   logic [2:0]   rwoff[2];
   logic [1:0]   raddr[2];
   logic [255:0] rdata[2];
   logic         lv[2], lerr[2], wv[2], busy[2];
   logic [6:0]   lidx[2];
   logic [255:0] ldata[2];
   logic [31:0]  wdata[2];
   int unsigned  wpb[2] = '{1, 3};

   iob_cache_line_fill_buffer_if #(.DATA_W(32), .BE_DATA_W(64), .WORD_OFFSET_W(3), .NLINES_W(7)) bus0 ();
   iob_cache_line_fill_buffer_if #(.DATA_W(32), .BE_DATA_W(256), .WORD_OFFSET_W(3), .NLINES_W(7)) bus1 ();

   assign bus0.replace_i     = replace[0];
   assign bus0.req_index_i   = ridx[0];
   assign bus0.req_woffset_i = rwoff[0];
   assign bus0.read_valid_i  = rvalid[0];
   assign bus0.read_addr_i   = raddr[0];
   assign bus0.read_rdata_i  = rdata[0][63:0];
   assign bus0.line_ready_i  = ready[0];
   assign lv[0]    = bus0.line_valid_o;
   assign lidx[0]  = bus0.line_index_o;
   assign ldata[0] = bus0.line_data_o;
   assign lerr[0]  = bus0.line_err_o;
   assign wv[0]    = bus0.word_valid_o;
   assign wdata[0] = bus0.word_rdata_o;
   assign busy[0]  = bus0.busy_o;

   assign bus1.replace_i     = replace[1];
   assign bus1.req_index_i   = ridx[1];
   assign bus1.req_woffset_i = rwoff[1];
   assign bus1.read_valid_i  = rvalid[1];
   assign bus1.read_addr_i   = raddr[1][0];
   assign bus1.read_rdata_i  = rdata[1];
   assign bus1.line_ready_i  = ready[1];
   assign lv[1]    = bus1.line_valid_o;
   assign lidx[1]  = bus1.line_index_o;
   assign ldata[1] = bus1.line_data_o;
   assign lerr[1]  = bus1.line_err_o;
   assign wv[1]    = bus1.word_valid_o;
   assign wdata[1] = bus1.word_rdata_o;
   assign busy[1]  = bus1.busy_o;

   iob_cache_line_fill_buffer #(
      .ADDR_W(32), .DATA_W(32), .BE_DATA_W(64), .WORD_OFFSET_W(3), .NLINES_W(7)
   ) u_dut0 (
      .clk_i(clk), .reset_n_i(reset_n), .bus(bus0)
   );

   iob_cache_line_fill_buffer #(
      .ADDR_W(32), .DATA_W(32), .BE_DATA_W(256), .WORD_OFFSET_W(3), .NLINES_W(7)
   ) u_dut1 (
      .clk_i(clk), .reset_n_i(reset_n), .bus(bus1)
   );

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s act=%h exp=%h", nm, act, exp);
      end
   endtask

   task automatic fail(input string nm, input string act, input string exp);
      n_chk++;
      n_bad++;
      $display("FAIL %s act=%s exp=%s", nm, act, exp);
   endtask

   function automatic logic [63:0] w64(input logic [7:0] t, input logic [7:0] k);
      return {t, k, 16'h0001, t, k, 16'h0000};
   endfunction

   // Monitor: pops the scoreboard whenever a DUT presents a word pulse or a line.
   task automatic mon(input int d);
      word_t w;
      line_t l;
      if (wv[d]) begin
         if (exp_word[d].size() == 0) begin
            fail($sformatf("d%0d_word_unexpected", d), $sformatf("%h", wdata[d]), "no pulse");
         end else begin
            w = exp_word[d].pop_front();
            chk($sformatf("d%0d_word_data", d), 256'(wdata[d]), 256'(w.data));
            chk($sformatf("d%0d_word_cycle", d), 256'(cyc), 256'(w.cyc));
         end
      end
      if (lv[d]) begin
         if (exp_line[d].size() == 0) begin
            fail($sformatf("d%0d_line_unexpected", d), $sformatf("%h", lidx[d]), "no line");
         end else begin
            l = exp_line[d][0];
            chk($sformatf("d%0d_line_index", d), 256'(lidx[d]), 256'(l.idx));
            chk($sformatf("d%0d_line_err", d), 256'(lerr[d]), 256'(l.err));
            if (l.chk_data) chk($sformatf("d%0d_line_data", d), ldata[d], l.data);
            if (!seen[d]) begin
               chk($sformatf("d%0d_line_latency", d), 256'(cyc), 256'(l.cyc));
               seen[d] = 1'b1;
            end
            if (ready[d]) begin
               void'(exp_line[d].pop_front());
               seen[d] = 1'b0;
            end
         end
      end
   endtask

   always @(negedge clk) begin
      if (reset_n) begin
         mon(0);
         mon(1);
      end
   end

   task automatic start(input int d, input logic [6:0] idx, input logic [2:0] woff);
      @(posedge clk); #1;
      replace[d] = 1'b1;
      ridx[d]    = idx;
      rwoff[d]   = woff;
   endtask

   task automatic beat(input int d, input logic [1:0] slot, input logic [255:0] data);
      int unsigned eff;
      int unsigned ws;
      @(posedge clk); #1;
      rvalid[d] = 1'b1;
      raddr[d]  = slot;
      rdata[d]  = data;
      eff = (d == 1) ? 0 : 32'(slot);
      ws  = 32'(rwoff[d]) % (1 << wpb[d]);
`ifdef IOB_CACHE_CRITICAL_WORD_FWD_EN
      if (eff == (32'(rwoff[d]) >> wpb[d])) exp_word[d].push_back('{data[ws*32 +: 32], cyc + 1});
`else
      if (eff == 99 || ws == 99) $display("unreachable");
`endif
   endtask

   task automatic finish(input int d, input logic [255:0] line, input logic err, input logic cd);
      @(posedge clk); #1;
      rvalid[d]  = 1'b0;
      replace[d] = 1'b0;
      exp_line[d].push_back('{ridx[d], line, err, cd, cyc + 1});
`ifndef IOB_CACHE_CRITICAL_WORD_FWD_EN
      if (!err) exp_word[d].push_back('{line[32'(rwoff[d])*32 +: 32], cyc + 1});
`endif
   endtask

   task automatic wait_done(input int d);
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (exp_line[d].size() == 0 && !busy[d]) return;
      end
      fail($sformatf("d%0d_timeout", d), "busy", "idle within 40 cycles");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog act=running exp=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      bit got;
      for (int d = 0; d < 2; d++) begin
         replace[d] = 0; rvalid[d] = 0; ready[d] = 1; ridx[d] = '0;
         rwoff[d] = '0; raddr[d] = '0; rdata[d] = '0; seen[d] = 0;
      end
      reset_n = 1'b1;
      #2 reset_n = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("d%0d_rst_valid", d), 256'(lv[d]), 256'(0));
         chk($sformatf("d%0d_rst_busy", d), 256'(busy[d]), 256'(0));
         chk($sformatf("d%0d_rst_data", d), ldata[d], 256'(0));
         chk($sformatf("d%0d_rst_word", d), 256'({wv[d], wdata[d]}), 256'(0));
      end
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;

      // Nominal 4-beat refill, word 5 lives in beat 2 upper half.
      start(0, 7'h15, 3'd5);
      for (int k = 0; k < 4; k++) beat(0, 2'(k), {192'h0, w64(8'hA0, 8'(k))});
      finish(0, {w64(8'hA0, 8'd3), w64(8'hA0, 8'd2), w64(8'hA0, 8'd1), w64(8'hA0, 8'd0)}, 1'b0, 1'b1);
      wait_done(0);

      // Backpressure: five cycles of stall before the consumer accepts.
      ready[0] = 1'b0;
      start(0, 7'h22, 3'd0);
      for (int k = 0; k < 4; k++) beat(0, 2'(k), {192'h0, w64(8'hC0, 8'(k))});
      finish(0, {w64(8'hC0, 8'd3), w64(8'hC0, 8'd2), w64(8'hC0, 8'd1), w64(8'hC0, 8'd0)}, 1'b0, 1'b1);
      got = 0;
      for (int i = 0; i < 10 && !got; i++) begin
         @(posedge clk); #1;
         got = lv[0];
      end
      if (!got) fail("d0_bp_valid_wait", "no valid", "valid");
      repeat (5) @(posedge clk);
      #1 ready[0] = 1'b1;
      @(posedge clk); #1;
      chk("d0_bp_idle_busy", 256'(busy[0]), 256'(0));
      chk("d0_bp_idle_valid", 256'(lv[0]), 256'(0));

      // Slave-error retry: full burst of A then full burst of B.
      start(0, 7'h41, 3'd3);
      for (int k = 0; k < 4; k++) beat(0, 2'(k), {192'h0, w64(8'hA0, 8'(k))});
      for (int k = 0; k < 4; k++) beat(0, 2'(k), {192'h0, w64(8'hB0, 8'(k))});
      finish(0, {w64(8'hB0, 8'd3), w64(8'hB0, 8'd2), w64(8'hB0, 8'd1), w64(8'hB0, 8'd0)}, 1'b0, 1'b1);
      wait_done(0);

      // Truncated: requested beat 3 never arrives.
      start(0, 7'h07, 3'd6);
      beat(0, 2'd0, {192'h0, w64(8'hD0, 8'd0)});
      beat(0, 2'd1, {192'h0, w64(8'hD0, 8'd1)});
      finish(0, '0, 1'b1, 1'b0);
      wait_done(0);

      // Async reset in the middle of a fill.
      start(0, 7'h2A, 3'd6);
      beat(0, 2'd0, {192'h0, w64(8'hE0, 8'd0)});
      beat(0, 2'd1, {192'h0, w64(8'hE0, 8'd1)});
      @(posedge clk); #1;
      rvalid[0]  = 1'b0;
      replace[0] = 1'b0;
      #2 reset_n = 1'b0;
      #1;
      chk("d0_midrst_valid", 256'(lv[0]), 256'(0));
      chk("d0_midrst_busy", 256'(busy[0]), 256'(0));
      chk("d0_midrst_index", 256'(lidx[0]), 256'(0));
      chk("d0_midrst_data", ldata[0], 256'(0));
      chk("d0_midrst_err", 256'(lerr[0]), 256'(0));
      chk("d0_midrst_word", 256'({wv[0], wdata[0]}), 256'(0));
      @(posedge clk); #1 reset_n = 1'b1;

      start(0, 7'h33, 3'd1);
      for (int k = 0; k < 4; k++) beat(0, 2'(k), {192'h0, w64(8'hF0, 8'(k))});
      finish(0, {w64(8'hF0, 8'd3), w64(8'hF0, 8'd2), w64(8'hF0, 8'd1), w64(8'hF0, 8'd0)}, 1'b0, 1'b1);
      wait_done(0);

      // Single-beat line; the beat address is deliberately nonzero and must be ignored.
      start(1, 7'h0C, 3'd7);
      beat(1, 2'd1, {w64(8'hC3, 8'd3), w64(8'hC2, 8'd2), w64(8'hC1, 8'd1), w64(8'hC0, 8'd0)});
      finish(1, {w64(8'hC3, 8'd3), w64(8'hC2, 8'd2), w64(8'hC1, 8'd1), w64(8'hC0, 8'd0)}, 1'b0, 1'b1);
      wait_done(1);

      start(1, 7'h5D, 3'd2);
      finish(1, '0, 1'b1, 1'b0);
      wait_done(1);

      repeat (3) @(posedge clk);
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("d%0d_lines_left", d), 256'(exp_line[d].size()), 256'(0));
         chk($sformatf("d%0d_words_left", d), 256'(exp_word[d].size()), 256'(0));
      end
      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
